// File: rtl/sv39_tlb_pkg.sv
// Shared Sv39 TLB types: PTE layout, cached entry format, access kinds and address helpers.
package sv39_tlb_pkg;

  localparam logic [3:0] SATP_BARE = 4'd0;
  localparam logic [3:0] SATP_SV39 = 4'd8;

  localparam logic [1:0] LVL_4K = 2'd0;
  localparam logic [1:0] LVL_2M = 2'd1;
  localparam logic [1:0] LVL_1G = 2'd2;

  typedef enum logic [1:0] {
    ACC_FETCH = 2'd0,
    ACC_LOAD  = 2'd1,
    ACC_STORE = 2'd2
  } acc_type_e;

  typedef struct packed {
    logic d;
    logic a;
    logic g;
    logic u;
    logic x;
    logic w;
    logic r;
    logic v;
  } pte_flags_t;

  typedef struct packed {
    logic [9:0]  rsvd;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    pte_flags_t  flags;
  } pte_t;

  // Flags that matter for the permission check (G is irrelevant without ASIDs).
  typedef struct packed {
    logic d;
    logic a;
    logic u;
    logic x;
    logic w;
    logic r;
    logic v;
  } perm_flags_t;

  typedef struct packed {
    logic        valid;
    logic [26:0] vpn;
    logic [43:0] ppn;
    logic [1:0]  level;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        a;
    logic        d;
  } tlb_entry_t;

  function automatic acc_type_e acc_decode(input logic [1:0] acc);
    case (acc)
      2'd0:    return ACC_FETCH;
      2'd2:    return ACC_STORE;
      default: return ACC_LOAD;
    endcase
  endfunction

  function automatic pte_t pte_decode(input logic [63:0] raw);
    return pte_t'(raw);
  endfunction

  function automatic logic va_canonical(input logic [63:0] va);
    return va[63:39] == {25{va[38]}};
  endfunction

  function automatic logic vpn_match(input logic [26:0] e_vpn, input logic [1:0] level,
                                     input logic [26:0] vpn);
    return (e_vpn[26:18] == vpn[26:18]) &&
           ((level == LVL_1G) || (e_vpn[17:9] == vpn[17:9])) &&
           ((level != LVL_4K) || (e_vpn[8:0] == vpn[8:0]));
  endfunction

  function automatic logic [55:0] make_pa(input logic [43:0] ppn, input logic [1:0] level,
                                          input logic [38:0] va);
    case (level)
      LVL_1G:  return {ppn[43:18], va[29:0]};
      LVL_2M:  return {ppn[43:9], va[20:0]};
      LVL_4K:  return {ppn, va[11:0]};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/sv39_tlb_if.sv
// Request/response, satp/sfence and page-table-walker signals of the Sv39 TLB.
interface sv39_tlb_if #(
    parameter int unsigned ADDR_WIDTH = 64
);
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_va;
    logic [1:0]            req_acc;
    logic                  priv_u;
    logic [3:0]            satp_mode;
    logic [43:0]           satp_ppn;
    logic                  sfence;

    logic                  resp_valid;
    logic [ADDR_WIDTH-1:0] resp_pa;
    logic                  resp_fault;

    logic                  walk_req;
    logic [ADDR_WIDTH-1:0] walk_va;
    logic [ADDR_WIDTH-1:0] walk_ppn_base;
    logic [ADDR_WIDTH-1:0] walk_pte;
    logic                  walk_finish;
    logic [1:0]            walk_level;

    modport master (
        output req_valid, req_va, req_acc, priv_u, satp_mode, satp_ppn, sfence,
        output walk_pte, walk_finish, walk_level,
        input  resp_valid, resp_pa, resp_fault,
        input  walk_req, walk_va, walk_ppn_base
    );

    modport slave (
        input  req_valid, req_va, req_acc, priv_u, satp_mode, satp_ppn, sfence,
        input  walk_pte, walk_finish, walk_level,
        output resp_valid, resp_pa, resp_fault,
        output walk_req, walk_va, walk_ppn_base
    );
endinterface

// File: rtl/sv39_tlb_perm_check.sv
// Leaf-PTE sanity and access-permission check shared by the hit path and the walk-response path.
module tlb_perm_check
    import sv39_tlb_pkg::*;
(
    input  perm_flags_t flags,
    input  logic [1:0]  level,
    input  logic [43:0] ppn,
    input  acc_type_e   acc,
    input  logic        priv_u,
    output logic        fault
);
    logic malformed;
    logic misaligned;
    logic no_access;
    logic unused_ppn;

    assign unused_ppn = ^ppn[43:18];

    always_comb begin
        malformed = !flags.v || (!flags.r && flags.w) || (!flags.r && !flags.w && !flags.x);

        // Superpage PPN must be aligned to the page size; level 3 never comes from a real walk.
        case (level)
            LVL_1G:  misaligned = |ppn[17:0];
            LVL_2M:  misaligned = |ppn[8:0];
            LVL_4K:  misaligned = 1'b0;
            default: misaligned = 1'b1;
        endcase

        case (acc)
            ACC_FETCH: no_access = !flags.x;
            ACC_STORE: no_access = !(flags.w && flags.d);
            default:   no_access = !flags.r;
        endcase

        fault = malformed || misaligned || no_access || !flags.a || (priv_u != flags.u);
    end
endmodule

// File: rtl/sv39_tlb.sv
// Fully-associative Sv39 TLB: zero-latency hits, single outstanding walk on a miss, RR refill.
module sv39_tlb
    import sv39_tlb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned ENTRIES    = 8
) (
    input logic       clk,
    input logic       rstn,
    sv39_tlb_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);

    typedef enum logic [1:0] {S_IDLE, S_WALK, S_WAIT, S_RESP} state_e;

    state_e                state, state_nx;
    tlb_entry_t            tlb [ENTRIES];
    logic [IDX_W-1:0]      rr_ptr, victim;
    logic                  victim_free;
    logic                  sfence_seen;
    logic [ADDR_WIDTH-1:0] walk_va_r, walk_base_r;
    logic [43:0]           ppn_r;
    perm_flags_t           flags_r;
    logic [1:0]            level_r;

    pte_t                  pte_in;
    logic                  unused_pte;
    acc_type_e             acc;
    logic                  is_sv39, canon;

    logic                  hit;
    logic [43:0]           hit_ppn;
    logic [1:0]            hit_level;
    perm_flags_t           hit_flags;
    logic                  hit_fault, walk_fault;

    logic                  resp_valid, resp_fault, walk_req, refill;
    logic [ADDR_WIDTH-1:0] resp_pa;

    assign pte_in     = pte_decode(bus.walk_pte);
    assign unused_pte = ^{pte_in.rsvd, pte_in.rsw, pte_in.flags.g};
    assign acc        = acc_decode(bus.req_acc);
    assign is_sv39    = (bus.satp_mode == SATP_SV39);
    assign canon      = va_canonical(bus.req_va);

    always_comb begin
        hit       = 1'b0;
        hit_ppn   = '0;
        hit_level = '0;
        hit_flags = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (tlb[i].valid && vpn_match(tlb[i].vpn, tlb[i].level, bus.req_va[38:12])) begin
                hit       = 1'b1;
                hit_ppn   = tlb[i].ppn;
                hit_level = tlb[i].level;
                hit_flags = '{d: tlb[i].d, a: tlb[i].a, u: tlb[i].u, x: tlb[i].x,
                              w: tlb[i].w, r: tlb[i].r, v: 1'b1};
            end
        end
    end

    always_comb begin
        victim      = rr_ptr;
        victim_free = 1'b0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!victim_free && !tlb[i].valid) begin
                victim      = IDX_W'(i);
                victim_free = 1'b1;
            end
        end
    end

    tlb_perm_check u_hit_chk (
        .flags  (hit_flags),
        .level  (hit_level),
        .ppn    (hit_ppn),
        .acc    (acc),
        .priv_u (bus.priv_u),
        .fault  (hit_fault)
    );

    tlb_perm_check u_resp_chk (
        .flags  (flags_r),
        .level  (level_r),
        .ppn    (ppn_r),
        .acc    (acc),
        .priv_u (bus.priv_u),
        .fault  (walk_fault)
    );

    always_comb begin
        state_nx   = state;
        resp_valid = 1'b0;
        resp_pa    = '0;
        resp_fault = 1'b0;
        walk_req   = 1'b0;
        refill     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (!is_sv39) begin
                        resp_valid = 1'b1;
                        resp_pa    = bus.req_va;
                    end else if (!canon) begin
                        resp_valid = 1'b1;
                        resp_fault = 1'b1;
                    end else if (hit) begin
                        resp_valid = 1'b1;
                        resp_fault = hit_fault;
                        resp_pa    = hit_fault ? '0
                                   : ADDR_WIDTH'(make_pa(hit_ppn, hit_level, bus.req_va[38:0]));
                    end else begin
                        state_nx = S_WALK;
                    end
                end
            end
            S_WALK: begin
                walk_req = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (bus.walk_finish) state_nx = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_fault = walk_fault;
                resp_pa    = walk_fault ? '0
                           : ADDR_WIDTH'(make_pa(ppn_r, level_r, walk_va_r[38:0]));
                // A flush seen while this walk was in flight means the PTE may be stale.
                refill     = !walk_fault && !sfence_seen && !bus.sfence;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            walk_va_r   <= '0;
            walk_base_r <= '0;
            ppn_r       <= '0;
            flags_r     <= '0;
            level_r     <= '0;
            sfence_seen <= 1'b0;
            rr_ptr      <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) tlb[i] <= '0;
        end else begin
            if (state == S_IDLE && state_nx == S_WALK) begin
                walk_va_r   <= bus.req_va;
                walk_base_r <= ADDR_WIDTH'(bus.satp_ppn);
            end
            if (state == S_WAIT && bus.walk_finish) begin
                ppn_r   <= pte_in.ppn;
                level_r <= bus.walk_level;
                flags_r <= '{d: pte_in.flags.d, a: pte_in.flags.a, u: pte_in.flags.u,
                             x: pte_in.flags.x, w: pte_in.flags.w, r: pte_in.flags.r,
                             v: pte_in.flags.v};
            end
            if (state == S_RESP)                      sfence_seen <= 1'b0;
            else if (bus.sfence && state != S_IDLE)   sfence_seen <= 1'b1;

            if (bus.sfence) begin
                for (int unsigned i = 0; i < ENTRIES; i++) tlb[i].valid <= 1'b0;
            end else if (refill) begin
                tlb[victim] <= '{valid: 1'b1, vpn: walk_va_r[38:12], ppn: ppn_r, level: level_r,
                                 u: flags_r.u, x: flags_r.x, w: flags_r.w, r: flags_r.r,
                                 a: flags_r.a, d: flags_r.d};
                if (!victim_free) rr_ptr <= rr_ptr + IDX_W'(1);
            end
        end
    end

    assign bus.resp_valid    = resp_valid;
    assign bus.resp_pa       = resp_pa;
    assign bus.resp_fault    = resp_fault;
    assign bus.walk_req      = walk_req;
    assign bus.walk_va       = walk_va_r;
    assign bus.walk_ppn_base = walk_base_r;

endmodule

// File: tb/tb_sv39_tlb.sv
// Self-checking bench for sv39_tlb: vector table plus flush, replacement and reset sequences.
module tb_sv39_tlb;
    import sv39_tlb_pkg::*;

    localparam int unsigned WALK_LAT = 3;
    localparam int          BUDGET   = 40;
    localparam logic [43:0] ROOT     = 44'h80000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sv39_tlb_if #(.ADDR_WIDTH(64)) bus ();

    sv39_tlb #(.ADDR_WIDTH(64), .ENTRIES(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        string       name;
        logic [3:0]  mode;
        logic [63:0] va;
        logic [1:0]  acc;
        logic        priv_u;
        logic [63:0] pte;
        logic [1:0]  lvl;
        int          walks;
        logic [63:0] pa;
        logic        fault;
    } vec_t;

    typedef struct {
        logic [63:0] pa;
        logic        fault;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sbq[$];
    vec_t vecs[$];

    // Walker model: answers each walk_req after WALK_LAT cycles, unaware of DUT reset.
    int          walk_count = 0;
    int          timer      = 0;
    logic [63:0] seen_va    = '0;
    logic [63:0] seen_base  = '0;
    logic [63:0] wpte_next  = '0;
    logic [1:0]  wlvl_next  = '0;

    initial begin
        bus.walk_finish = 1'b0;
        bus.walk_pte    = '0;
        bus.walk_level  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.walk_finish = 1'b0;
            if (bus.walk_req) begin
                walk_count++;
                seen_va   = bus.walk_va;
                seen_base = bus.walk_ppn_base;
                timer     = WALK_LAT;
            end else if (timer > 0) begin
                timer--;
                if (timer == 0) begin
                    bus.walk_finish = 1'b1;
                    bus.walk_pte    = wpte_next;
                    bus.walk_level  = wlvl_next;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [63:0] mk_pte(input logic [43:0] ppn, input logic [7:0] fl);
        return (64'(ppn) << 10) | 64'(fl);
    endfunction

    function automatic vec_t mk(input string name, input logic [3:0] mode, input logic [63:0] va,
                                input logic [1:0] acc, input logic priv_u, input logic [63:0] pte,
                                input logic [1:0] lvl, input int walks, input logic [63:0] pa,
                                input logic fault);
        vec_t v;
        v.name = name; v.mode = mode; v.va = va; v.acc = acc; v.priv_u = priv_u;
        v.pte = pte; v.lvl = lvl; v.walks = walks; v.pa = pa; v.fault = fault;
        return v;
    endfunction

    // 4 KiB page p mapped to PPN 0x80000+p, RWX-less load page (0xC7: D A W R V).
    function automatic vec_t page(input int p, input int walks);
        logic [63:0] va;
        va = (64'(p) << 12) | 64'h10;
        return mk($sformatf("page%0d", p), SATP_SV39, va, 2'd1, 1'b0,
                  mk_pte(ROOT + 44'(p), 8'hC7), LVL_4K, walks,
                  (64'(ROOT + 44'(p)) << 12) | 64'h10, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic sfence_pulse();
        @(posedge clk); #1;
        bus.sfence = 1'b1;
        @(posedge clk); #1;
        bus.sfence = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input bit sf_in_wait);
        exp_t e;
        int   w0;
        int   since;
        bit   got;
        sbq.push_back('{pa: v.pa, fault: v.fault});
        wpte_next = v.pte;
        wlvl_next = v.lvl;
        w0    = walk_count;
        since = 0;
        got   = 1'b0;
        @(posedge clk); #1;
        bus.satp_mode = v.mode;
        bus.req_va    = v.va;
        bus.req_acc   = v.acc;
        bus.priv_u    = v.priv_u;
        bus.req_valid = 1'b1;
        for (int c = 0; c < BUDGET && !got; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                e = sbq.pop_front();
                chk({v.name, ".pa"}, bus.resp_pa, e.pa);
                chk({v.name, ".fault"}, 64'(bus.resp_fault), 64'(e.fault));
                if (v.walks == 0) chk({v.name, ".latency"}, 64'(c), 64'd0);
                got = 1'b1;
            end else begin
                @(posedge clk); #2;
                if (walk_count != w0) since++;
                bus.sfence = sf_in_wait && (since == 2);
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.timeout: no resp_valid within %0d cycles", v.name, BUDGET);
            sbq.delete();
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.sfence    = 1'b0;
        chk({v.name, ".walks"}, 64'(walk_count - w0), 64'(v.walks));
        if (v.walks != 0) begin
            chk({v.name, ".walk_va"}, seen_va, v.va);
            chk({v.name, ".walk_base"}, seen_base, 64'(ROOT));
        end
    endtask

    initial begin
        int  w0;
        bit  launched;
        bus.req_valid = 1'b0;
        bus.req_va    = '0;
        bus.req_acc   = 2'd1;
        bus.priv_u    = 1'b0;
        bus.satp_mode = SATP_SV39;
        bus.satp_ppn  = ROOT;
        bus.sfence    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst.resp_fault", 64'(bus.resp_fault), 64'd0);
        chk("rst.resp_pa", bus.resp_pa, 64'd0);
        chk("rst.walk_req", 64'(bus.walk_req), 64'd0);
        chk("rst.walk_va", bus.walk_va, 64'd0);
        chk("rst.walk_base", bus.walk_ppn_base, 64'd0);
        rstn = 1'b1;

        vecs.push_back(mk("bare", SATP_BARE, 64'h1234_5678, 2'd1, 1'b0, 64'd0, 2'd0, 0, 64'h1234_5678, 1'b0));
        vecs.push_back(mk("bare_mode5", 4'd5, 64'hFFFF_0000_0000_0001, 2'd2, 1'b1, 64'd0, 2'd0, 0, 64'hFFFF_0000_0000_0001, 1'b0));
        vecs.push_back(mk("miss_l0", SATP_SV39, 64'h4000_1234, 2'd1, 1'b0, mk_pte(44'h80123, 8'hC7), 2'd0, 1, 64'h8012_3234, 1'b0));
        vecs.push_back(mk("hit_l0", SATP_SV39, 64'h4000_1234, 2'd1, 1'b0, mk_pte(44'h80123, 8'hC7), 2'd0, 0, 64'h8012_3234, 1'b0));
        vecs.push_back(mk("acc3_as_load", SATP_SV39, 64'h4000_1ABC, 2'd3, 1'b0, 64'd0, 2'd0, 0, 64'h8012_3ABC, 1'b0));
        vecs.push_back(mk("l1_misalign", SATP_SV39, 64'h0020_0ABC, 2'd0, 1'b0, mk_pte(44'h80201, 8'hCB), 2'd1, 1, 64'd0, 1'b1));
        vecs.push_back(mk("l1_misalign_again", SATP_SV39, 64'h0020_0ABC, 2'd0, 1'b0, mk_pte(44'h80201, 8'hCB), 2'd1, 1, 64'd0, 1'b1));
        vecs.push_back(mk("l1_miss", SATP_SV39, 64'h0020_0ABC, 2'd0, 1'b0, mk_pte(44'h80200, 8'hCB), 2'd1, 1, 64'h8020_0ABC, 1'b0));
        vecs.push_back(mk("l1_hit", SATP_SV39, 64'h0020_0ABC, 2'd0, 1'b0, 64'd0, 2'd1, 0, 64'h8020_0ABC, 1'b0));
        vecs.push_back(mk("pte_v0", SATP_SV39, 64'h0060_0000, 2'd1, 1'b0, mk_pte(44'h80300, 8'hC6), 2'd0, 1, 64'd0, 1'b1));
        vecs.push_back(mk("store_d0", SATP_SV39, 64'h0070_0010, 2'd2, 1'b0, mk_pte(44'h80400, 8'h47), 2'd0, 1, 64'd0, 1'b1));
        vecs.push_back(mk("user_on_s_page", SATP_SV39, 64'h4000_1234, 2'd1, 1'b1, 64'd0, 2'd0, 0, 64'd0, 1'b1));
        vecs.push_back(mk("fetch_no_x", SATP_SV39, 64'h4000_1234, 2'd0, 1'b0, 64'd0, 2'd0, 0, 64'd0, 1'b1));
        vecs.push_back(mk("noncanonical", SATP_SV39, 64'h0000_0080_0000_0000, 2'd1, 1'b0, 64'd0, 2'd0, 0, 64'd0, 1'b1));
        vecs.push_back(mk("r0w1", SATP_SV39, 64'h0090_0000, 2'd1, 1'b0, mk_pte(44'h80600, 8'hC5), 2'd0, 1, 64'd0, 1'b1));
        vecs.push_back(mk("nonleaf_l0", SATP_SV39, 64'h00A0_0000, 2'd1, 1'b0, mk_pte(44'h80700, 8'hC1), 2'd0, 1, 64'd0, 1'b1));
        vecs.push_back(mk("user_store", SATP_SV39, 64'h0080_0008, 2'd2, 1'b1, mk_pte(44'h80500, 8'hD7), 2'd0, 1, 64'h8050_0008, 1'b0));
        vecs.push_back(mk("s_on_user_page", SATP_SV39, 64'h0080_0008, 2'd1, 1'b0, 64'd0, 2'd0, 0, 64'd0, 1'b1));
        vecs.push_back(mk("l2_miss", SATP_SV39, 64'h8000_1000, 2'd1, 1'b0, mk_pte(44'h80000, 8'hCF), 2'd2, 1, 64'h8000_1000, 1'b0));
        vecs.push_back(mk("l2_hit", SATP_SV39, 64'hBFFF_FFF8, 2'd2, 1'b0, 64'd0, 2'd2, 0, 64'hBFFF_FFF8, 1'b0));
        vecs.push_back(mk("l2_misalign", SATP_SV39, 64'hC000_0000, 2'd1, 1'b0, mk_pte(44'h80200, 8'hCF), 2'd2, 1, 64'd0, 1'b1));

        foreach (vecs[i]) run_vec(vecs[i], 1'b0);

        // Replacement: after a flush, nine pages into eight entries evicts entry 0 (page 1).
        sfence_pulse();
        for (int p = 1; p <= 9; p++) run_vec(page(p, 1), 1'b0);
        run_vec(page(9, 0), 1'b0);
        run_vec(page(1, 1), 1'b0);
        run_vec(page(3, 0), 1'b0);
        run_vec(page(2, 1), 1'b0);

        sfence_pulse();
        run_vec(page(9, 1), 1'b0);

        // Flush while the walk is outstanding: answer delivered, nothing cached.
        run_vec(page(5, 1), 1'b1);
        run_vec(page(5, 1), 1'b0);
        run_vec(page(9, 1), 1'b0);

        // Reset during WAIT: walk abandoned, late walk_finish ignored, TLB empty.
        run_vec(page(7, 1), 1'b0);
        wpte_next = mk_pte(ROOT + 44'd6, 8'hC7);
        wlvl_next = LVL_4K;
        w0        = walk_count;
        launched  = 1'b0;
        @(posedge clk); #1;
        bus.req_va    = 64'h6010;
        bus.req_acc   = 2'd1;
        bus.priv_u    = 1'b0;
        bus.req_valid = 1'b1;
        for (int c = 0; c < BUDGET && !launched; c++) begin
            @(posedge clk); #2;
            launched = (walk_count != w0);
        end
        chk("rstwalk.launched", 64'(launched), 64'd1);
        @(posedge clk); #2;
        bus.req_valid = 1'b0;
        rstn          = 1'b0;
        #1;
        chk("rstwalk.resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rstwalk.walk_req", 64'(bus.walk_req), 64'd0);
        chk("rstwalk.walk_va", bus.walk_va, 64'd0);
        chk("rstwalk.walk_base", bus.walk_ppn_base, 64'd0);
        chk("rstwalk.resp_pa", bus.resp_pa, 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("stray_finish.resp_valid[%0d]", c), 64'(bus.resp_valid), 64'd0);
            chk($sformatf("stray_finish.walk_req[%0d]", c), 64'(bus.walk_req), 64'd0);
        end
        run_vec(page(7, 1), 1'b0);
        run_vec(page(7, 0), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
